cam_line_capture: RTL and testbench
===================================

# cam_line_capture

Upstream feeder for the pupil detector: accepts the inward-facing camera's raster pixel stream one 8-bit grayscale pixel at a time and assembles each row into a flat line vector. Completed lines are handed downstream through a valid/ack handshake. The block also reports line number, end of frame and overflow. Assembly and output registers are double-buffered, so the camera can fill row N+1 while the detector is still scanning row N.

## Interface
- MAX_RESOLUTION, 112, pixels per row and rows per frame (square sensor); must be ≤ 255.
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low; sampled on the rising edge of clock.
- frame_start  input  1  one-cycle pulse marking the start of a new frame; the first pixel may arrive in the same cycle.
- pixel_data  input  8  grayscale pixel (0 = black, 255 = white).
- pixel_valid  input  1  pixel_data is sampled when high; raster order, column 0 first.
- line_ack  input  1  downstream has consumed line_data; only meaningful while line_valid = 1.
- line_data  output  MAX_RESOLUTION*8  completed row; pixel c is at bits [8c+7 : 8c].
- line_valid  output  1  line_data and line_number are valid; held until acked.
- line_number  output  8  row index (0 … MAX_RESOLUTION-1) of line_data.
- frame_capture_done  output  1  one-cycle pulse when the last row of a frame is transferred to the output register.
- overflow  output  1  sticky; a completed row was dropped because the output register was still occupied.

## Operation
- States:
  - IDLE: wait for frame_start.
  - CAPTURE: collect pixels.
- IDLE
  - pixel_valid is ignored.
  - On frame_start: col = 0, row = 0, go to CAPTURE.
  - If pixel_valid is high in the same cycle as frame_start, that pixel is stored as column 0.
- CAPTURE
  - Each pixel_valid writes pixel_data into the assembly buffer at col, then increments col.
  - When col = MAX_RESOLUTION-1 and pixel_valid is high, the row is complete.
- Row transfer
  - Condition: the output register is free, meaning line_valid = 0, or line_valid = 1 with line_ack = 1 in the same cycle.
  - If free: copy the assembly buffer (including the final pixel) into line_data, set line_number = row, set line_valid = 1.
  - If not free: drop the row, set overflow = 1, leave line_data, line_number and line_valid unchanged.
  - In both cases: col = 0, row = row + 1.
- End of frame: completing row MAX_RESOLUTION-1 returns the FSM to IDLE.
  - If that row was transferred, pulse frame_capture_done.
  - If that row was dropped, no pulse.
- Handshake
  - line_ack with line_valid = 1 clears line_valid next cycle, unless a new row transfers in the same cycle; then line_valid stays 1 with the new contents.
  - line_ack with line_valid = 0 is ignored.
- frame_start while in CAPTURE
  - Discard the partial row and restart at col = 0, row = 0.
  - A pending output line is kept, and overflow is kept.
- Counters
  - col and row are 8-bit and never exceed MAX_RESOLUTION-1; there is no wrap beyond the row count.
- overflow is cleared only by reset.

## Timing
- Reset values (on a reset = 0 edge):
  - state = IDLE; col = 0; row = 0.
  - line_valid = 0; line_data = 0; line_number = 0.
  - frame_capture_done = 0; overflow = 0.
- Reset takes effect mid-frame, discarding all data.
- Latency: line_valid, line_data and line_number update on the clock edge after the cycle in which the last pixel of the row is sampled (1 cycle).
- frame_capture_done is high for exactly that same cycle for the last row.
- Throughput: one pixel per clock sustained; back-to-back rows have no gap.
- line_valid deasserts on the edge following a line_ack = 1 cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset behaviour
  - Stimulus: hold reset = 0 for 2 cycles with random pixel_valid and frame_start.
  - Response: all outputs 0; state stays IDLE.
  - Pixels applied before frame_start leave line_valid = 0.
- Single row
  - Stimulus: frame_start, then 112 consecutive pixels with value = column index, ack immediately.
  - Response: line_valid rises 1 cycle after pixel 111.
  - line_data[7:0] = 0 and line_data[895:888] = 111; line_number = 0.
- Full frame with continuous ack
  - Stimulus: 112 rows at one pixel per clock, line_ack tied high.
  - Response: line_number steps 0…111; overflow = 0.
  - frame_capture_done pulses once, in the cycle line_number = 111 appears; FSM returns to IDLE.
- Overflow
  - Stimulus: never ack row 0, then send rows 1 and 2.
  - Response: line_data still holds row 0 with line_number = 0; overflow = 1 and stays 1 after a later ack.
- Simultaneous ack and transfer
  - Stimulus: assert line_ack in the same cycle as the last pixel of row 1.
  - Response: line_valid stays 1 with no gap; line_number = 1; no overflow.
- Mid-frame restart and reset
  - frame_start at col = 50 of row 3: the next completed line has line_number = 0 and carries the new pixels.
  - reset = 0 at col = 20: all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/cam_line_capture.sv
// cam_line_capture
// Assembles a raster grayscale pixel stream into one flat vector per row and
// hands each completed row downstream over a valid/ack handshake. While the
// downstream detector scans the held output row, the next row fills the
// assembly buffer.
//
// Ports
//   clock              system clock, rising edge
//   reset              synchronous, active-low
//   frame_start        one-cycle pulse; the first pixel may share the cycle
//   pixel_data[7:0]    grayscale pixel, sampled when pixel_valid is high
//   pixel_valid        pixel qualifier, raster order, column 0 first
//   line_ack           downstream consumed line_data (only while line_valid)
//   line_data          completed row, pixel c at bits [8c+7:8c]
//   line_valid         line_data/line_number valid, held until acked
//   line_number[7:0]   row index of line_data
//   frame_capture_done one-cycle pulse when the last row of a frame transfers
//   overflow           sticky, a completed row was dropped (cleared by reset)
module cam_line_capture #(
  parameter int MAX_RESOLUTION = 112
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic [7:0]                  pixel_data,
  input  logic                        pixel_valid,
  input  logic                        line_ack,
  output logic [MAX_RESOLUTION*8-1:0] line_data,
  output logic                        line_valid,
  output logic [7:0]                  line_number,
  output logic                        frame_capture_done,
  output logic                        overflow
);

  localparam int         DATA_W = 8;
  localparam int         IDX_W  = (MAX_RESOLUTION > 1) ? $clog2(MAX_RESOLUTION) : 1;
  localparam logic [7:0] LAST   = 8'(MAX_RESOLUTION - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [7:0]        col, col_next;
  logic [7:0]        row, row_next;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic              xfer;
  logic              drop;
  logic              done_next;
  logic              out_free;

  logic [DATA_W-1:0]          pix_mem [MAX_RESOLUTION];
  logic [MAX_RESOLUTION*8-1:0] line_next;

  // Row leaving the assembly buffer: the final pixel is taken straight from the
  // input so the row can transfer in the same cycle that pixel is sampled.
  for (genvar c = 0; c < MAX_RESOLUTION; c++) begin : g_pack
    if (c == MAX_RESOLUTION - 1) begin : g_last
      assign line_next[8*c +: 8] = pixel_data;
    end else begin : g_mem
      assign line_next[8*c +: 8] = pix_mem[c];
    end
  end

  // Next-state, counters and transfer decision
  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;
    wr_en      = 1'b0;
    wr_idx     = col[IDX_W-1:0];
    xfer       = 1'b0;
    drop       = 1'b0;
    done_next  = 1'b0;
    // An ack in the same cycle frees the output register for a new row.
    out_free   = !line_valid || line_ack;

    case (state)
      IDLE: begin
        if (frame_start) begin
          state_next = CAPTURE;
          row_next   = 8'd0;
          col_next   = 8'd0;
          if (pixel_valid) begin
            wr_en    = 1'b1;
            wr_idx   = '0;
            col_next = 8'd1;
          end
        end
      end
      CAPTURE: begin
        if (frame_start) begin
          // Restart discards the partial row; the pending output line stays.
          row_next = 8'd0;
          col_next = 8'd0;
          if (pixel_valid) begin
            wr_en    = 1'b1;
            wr_idx   = '0;
            col_next = 8'd1;
          end
        end else if (pixel_valid) begin
          wr_en = 1'b1;
          if (col == LAST) begin
            col_next = 8'd0;
            if (out_free) begin
              xfer = 1'b1;
            end else begin
              drop = 1'b1;
            end
            if (row == LAST) begin
              state_next = IDLE;
              row_next   = 8'd0;
              done_next  = out_free;
            end else begin
              row_next = row + 8'd1;
            end
          end else begin
            col_next = col + 8'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state              <= IDLE;
      col                <= 8'd0;
      row                <= 8'd0;
      line_valid         <= 1'b0;
      line_number        <= 8'd0;
      line_data          <= '0;
      frame_capture_done <= 1'b0;
      overflow           <= 1'b0;
    end else begin
      state              <= state_next;
      col                <= col_next;
      row                <= row_next;
      frame_capture_done <= done_next;
      if (drop) begin
        overflow <= 1'b1;
      end
      if (xfer) begin
        line_valid  <= 1'b1;
        line_number <= row;
        line_data   <= line_next;
      end else if (line_ack) begin
        line_valid <= 1'b0;
      end
    end
  end

  // Assembly buffer (data only, no reset needed: every column is rewritten
  // before a row can complete)
  always_ff @(posedge clock) begin
    if (wr_en) begin
      pix_mem[wr_idx] <= pixel_data;
    end
  end

endmodule

// File: tb/tb_cam_line_capture.sv
module tb_cam_line_capture;

  localparam int MAXR = 112;
  localparam int W    = MAXR * 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic [7:0]    pixel_data = 8'd0;
  logic          pixel_valid = 1'b0;
  logic          line_ack = 1'b0;
  logic [W-1:0]  line_data;
  logic          line_valid;
  logic [7:0]    line_number;
  logic          frame_capture_done;
  logic          overflow;

  cam_line_capture #(.MAX_RESOLUTION(MAXR)) dut (
    .clock              (clock),
    .reset              (reset),
    .frame_start        (frame_start),
    .pixel_data         (pixel_data),
    .pixel_valid        (pixel_valid),
    .line_ack           (line_ack),
    .line_data          (line_data),
    .line_valid         (line_valid),
    .line_number        (line_number),
    .frame_capture_done (frame_capture_done),
    .overflow           (overflow)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Behavioural reference: a row is a queue of bytes that is emitted once it
  // holds a full row's worth of pixels.
  bit           m_cap;
  byte unsigned m_q[$];
  int           m_row;
  bit           m_lv;
  int           m_ln;
  logic [W-1:0] m_ld;
  bit           m_done;
  bit           m_ovf;

  int           done_seen;
  int           done_ln;
  byte unsigned last_row[MAXR];
  byte unsigned row0[MAXR];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit had_room;
    bit moved;
    if (!reset) begin
      m_cap = 0; m_q.delete(); m_row = 0;
      m_lv = 0; m_ln = 0; m_ld = '0; m_done = 0; m_ovf = 0;
      return;
    end
    had_room = !m_lv || line_ack;
    moved    = 0;
    m_done   = 0;
    if (frame_start) begin
      m_cap = 1; m_q.delete(); m_row = 0;
      if (pixel_valid) m_q.push_back(pixel_data);
    end else if (m_cap && pixel_valid) begin
      m_q.push_back(pixel_data);
      if (m_q.size() == MAXR) begin
        if (had_room) begin
          for (int i = 0; i < MAXR; i++) m_ld[8*i +: 8] = m_q[i];
          m_ln  = m_row;
          moved = 1;
          if (m_row == MAXR - 1) m_done = 1;
        end else begin
          m_ovf = 1;
        end
        m_q.delete();
        if (m_row == MAXR - 1) begin
          m_cap = 0; m_row = 0;
        end else begin
          m_row++;
        end
      end
    end
    if (moved) m_lv = 1;
    else if (m_lv && line_ack) m_lv = 0;
  endtask

  task automatic check_all();
    chk("line_valid", W'(line_valid), W'(m_lv));
    chk("line_number", W'(line_number), W'(m_ln));
    chk("frame_capture_done", W'(frame_capture_done), W'(m_done));
    chk("overflow", W'(overflow), W'(m_ovf));
    if (m_lv) chk("line_data", line_data, m_ld);
    if (frame_capture_done) begin
      done_seen++;
      done_ln = line_number;
    end
  endtask

  // Inputs are set at the falling edge, sampled at the rising edge, and the
  // outputs are compared at the next falling edge.
  task automatic cycle();
    @(posedge clock);
    model_update();
    @(negedge clock);
    check_all();
  endtask

  task automatic pix(input bit f, input bit v, input byte unsigned d, input bit a);
    frame_start = f; pixel_valid = v; pixel_data = d; line_ack = a;
    cycle();
  endtask

  // mode 0: pixel = column index, else random. ack_mode 0 never, 1 always,
  // 2 only on the last pixel.
  task automatic send_row(input int mode, input bit with_fs, input int ack_mode);
    for (int c = 0; c < MAXR; c++) begin
      byte unsigned d;
      bit a;
      d = (mode == 0) ? 8'(c) : 8'($urandom_range(0, 255));
      a = (ack_mode == 1) || (ack_mode == 2 && c == MAXR - 1);
      last_row[c] = d;
      pix(with_fs && c == 0, 1'b1, d, a);
    end
  endtask

  initial begin
    // Reset held with random activity
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pix(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
    end
    chk("reset_lv", W'(line_valid), W'(0));
    chk("reset_data", line_data, '0);
    chk("reset_ovf", W'(overflow), W'(0));
    reset = 1'b1;
    for (int i = 0; i < 130; i++) pix(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    chk("idle_pixels_lv", W'(line_valid), W'(0));

    // Single row, value = column index
    send_row(0, 1'b1, 1);
    chk("single_lv", W'(line_valid), W'(1));
    chk("single_b0", W'(line_data[7:0]), W'(0));
    chk("single_b111", W'(line_data[895:888]), W'(111));
    chk("single_ln", W'(line_number), W'(0));

    // Full frame with continuous ack
    done_seen = 0; done_ln = -1;
    for (int r = 0; r < MAXR; r++) send_row(1, r == 0, 1);
    for (int i = 0; i < 3; i++) pix(1'b0, 1'b1, 8'hAA, 1'b1);
    chk("frame_done_count", W'(done_seen), W'(1));
    chk("frame_done_ln", W'(done_ln), W'(111));
    chk("frame_ovf", W'(overflow), W'(0));
    chk("frame_idle_lv", W'(line_valid), W'(0));

    // Overflow: row 0 never acked while rows 1 and 2 complete
    send_row(1, 1'b1, 0);
    row0 = last_row;
    send_row(1, 1'b0, 0);
    send_row(1, 1'b0, 0);
    chk("ovf_ln", W'(line_number), W'(0));
    chk("ovf_b0", W'(line_data[7:0]), W'(row0[0]));
    chk("ovf_b57", W'(line_data[463:456]), W'(row0[57]));
    chk("ovf_flag", W'(overflow), W'(1));
    pix(1'b0, 1'b0, 8'd0, 1'b1);
    pix(1'b0, 1'b0, 8'd0, 1'b0);
    chk("ovf_sticky", W'(overflow), W'(1));
    chk("ovf_acked_lv", W'(line_valid), W'(0));

    // Simultaneous ack and transfer
    reset = 1'b0;
    pix(1'b0, 1'b0, 8'd0, 1'b0);
    reset = 1'b1;
    send_row(1, 1'b1, 0);
    send_row(1, 1'b0, 2);
    chk("simul_lv", W'(line_valid), W'(1));
    chk("simul_ln", W'(line_number), W'(1));
    chk("simul_ovf", W'(overflow), W'(0));

    // Mid-frame restart at column 50 of row 3
    send_row(1, 1'b0, 1);
    for (int c = 0; c < 50; c++) pix(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
    send_row(1, 1'b1, 0);
    chk("restart_ln", W'(line_number), W'(0));
    chk("restart_b0", W'(line_data[7:0]), W'(last_row[0]));
    chk("restart_b111", W'(line_data[895:888]), W'(last_row[111]));

    // Reset at column 20 with a line pending
    for (int c = 0; c < 20; c++) pix(1'b0, 1'b1, 8'($urandom_range(1, 255)), 1'b0);
    reset = 1'b0;
    pix(1'b0, 1'b1, 8'h55, 1'b0);
    chk("midreset_lv", W'(line_valid), W'(0));
    chk("midreset_data", line_data, '0);
    chk("midreset_ln", W'(line_number), W'(0));
    reset = 1'b1;

    // Randomized soak
    pix(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 6000; i++) begin
      reset = ($urandom_range(0, 2999) != 0);
      pix(($urandom_range(0, 1999) == 0), ($urandom_range(0, 9) != 0),
          8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        pix(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
